// File: rtl/game_ctl.sv
// game_ctl: round and shot sequencer for the Duck Hunt game.
// It decides when ctl_duck spawns, kills or releases a duck, and it keeps
// the shot, hit, duck, round and score counters that the HUD displays.
// Every output is registered. The pulses are exactly one clock wide.
module game_ctl #(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6,
  parameter int FLY_TIMEOUT     = 300,
  parameter int PAUSE_FRAMES    = 60,
  parameter int HIT_POINTS      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        trigger,
  input  logic        on_target,
  input  logic        duck_escaped,
  output logic        duck_spawn,
  output logic        duck_kill,
  output logic        fly_away,
  output logic [1:0]  shots_left,
  output logic [3:0]  ducks_done,
  output logic [3:0]  hits,
  output logic [3:0]  round,
  output logic [15:0] score,
  output logic [2:0]  state,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    FLY       = 3'd2,
    FALL      = 3'd3,
    ESCAPE    = 3'd4,
    NEXT      = 3'd5,
    ROUND_END = 3'd6,
    OVER      = 3'd7
  } state_t;

  localparam logic [15:0] FLY_LAST    = 16'(FLY_TIMEOUT - 1);
  localparam logic [15:0] PAUSE_LAST  = 16'(PAUSE_FRAMES - 1);
  localparam logic [1:0]  SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]  DUCKS_LIMIT = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0]  PASS_LIMIT  = 4'(PASS_HITS);
  localparam logic [15:0] POINTS      = 16'(HIT_POINTS);

  state_t      state_reg, state_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0]  shots_reg, shots_next;
  logic [3:0]  ducks_reg, ducks_next;
  logic [3:0]  hits_reg, hits_next;
  logic [3:0]  round_reg, round_next;
  logic [15:0] score_reg, score_next;
  logic        spawn_reg, spawn_next;
  logic        kill_reg, kill_next;
  logic        fly_reg, fly_next;
  logic        over_reg, over_next;

  // Score increment for a hit in the current round, with 16-bit saturation.
  logic [15:0] hit_gain;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic        pause_done;
  logic [3:0]  ducks_inc;

  // Arithmetic that several states share.
  always_comb begin
    hit_gain   = POINTS * {12'd0, round_reg};
    score_sum  = {1'b0, score_reg} + {1'b0, hit_gain};
    score_sat  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    pause_done = new_frame && (frame_cnt_reg == PAUSE_LAST);
    ducks_inc  = ducks_reg + 4'd1;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= 16'd0;
      shots_reg     <= 2'd0;
      ducks_reg     <= 4'd0;
      hits_reg      <= 4'd0;
      round_reg     <= 4'd1;
      score_reg     <= 16'd0;
      spawn_reg     <= 1'b0;
      kill_reg      <= 1'b0;
      fly_reg       <= 1'b0;
      over_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      shots_reg     <= shots_next;
      ducks_reg     <= ducks_next;
      hits_reg      <= hits_next;
      round_reg     <= round_next;
      score_reg     <= score_next;
      spawn_reg     <= spawn_next;
      kill_reg      <= kill_next;
      fly_reg       <= fly_next;
      over_reg      <= over_next;
    end
  end

  // Next-state logic and next values for the counters and outputs.
  always_comb begin
    logic resolved;
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    shots_next     = shots_reg;
    ducks_next     = ducks_reg;
    hits_next      = hits_reg;
    round_next     = round_reg;
    score_next     = score_reg;
    spawn_next     = 1'b0;
    kill_next      = 1'b0;
    fly_next       = fly_reg;
    over_next      = over_reg;
    resolved       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          round_next = 4'd1;
          score_next = 16'd0;
          hits_next  = 4'd0;
          ducks_next = 4'd0;
          state_next = SPAWN;
        end
      end

      SPAWN: begin
        spawn_next     = 1'b1;
        shots_next     = SHOTS_INIT;
        frame_cnt_next = 16'd0;
        state_next     = FLY;
      end

      FLY: begin
        // The frame tick is always counted. A shot that decides the duck
        // then overrides the count and the transition.
        if (new_frame) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end
        if (trigger && (shots_reg != 2'd0)) begin
          shots_next = shots_reg - 2'd1;
          if (on_target) begin
            kill_next      = 1'b1;
            hits_next      = hits_reg + 4'd1;
            score_next     = score_sat;
            frame_cnt_next = 16'd0;
            state_next     = FALL;
            resolved       = 1'b1;
          end else if (shots_reg == 2'd1) begin
            fly_next       = 1'b1;
            frame_cnt_next = 16'd0;
            state_next     = ESCAPE;
            resolved       = 1'b1;
          end
        end
        // A miss that leaves shots remaining does not decide the duck, so
        // an escape or a timeout in the same cycle still takes effect.
        if (!resolved) begin
          if (duck_escaped) begin
            frame_cnt_next = 16'd0;
            state_next     = ESCAPE;
          end else if (new_frame && (frame_cnt_reg == FLY_LAST)) begin
            fly_next       = 1'b1;
            frame_cnt_next = 16'd0;
            state_next     = ESCAPE;
          end
        end
      end

      FALL, ESCAPE: begin
        if (pause_done) begin
          frame_cnt_next = 16'd0;
          fly_next       = 1'b0;
          state_next     = NEXT;
        end else if (new_frame) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end
      end

      NEXT: begin
        ducks_next     = ducks_inc;
        frame_cnt_next = 16'd0;
        state_next     = (ducks_inc == DUCKS_LIMIT) ? ROUND_END : SPAWN;
      end

      ROUND_END: begin
        if (pause_done) begin
          frame_cnt_next = 16'd0;
          if (hits_reg >= PASS_LIMIT) begin
            round_next = (round_reg == 4'd15) ? 4'd15 : round_reg + 4'd1;
            hits_next  = 4'd0;
            ducks_next = 4'd0;
            state_next = SPAWN;
          end else begin
            over_next  = 1'b1;
            state_next = OVER;
          end
        end else if (new_frame) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end
      end

      OVER: begin
        if (trigger) begin
          over_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign duck_spawn = spawn_reg;
  assign duck_kill  = kill_reg;
  assign fly_away   = fly_reg;
  assign shots_left = shots_reg;
  assign ducks_done = ducks_reg;
  assign hits       = hits_reg;
  assign round      = round_reg;
  assign score      = score_reg;
  assign state      = state_reg;
  assign game_over  = over_reg;

endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: randomized scoreboard bench for game_ctl.
// A driver applies random clicks, frame ticks, escapes and resets. It steps
// a behavioural game model and queues the expected outputs for each cycle.
// A monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_game_ctl;

  localparam int SHOTS  = 3;
  localparam int DUCKS  = 10;
  localparam int PASS   = 6;
  localparam int TMO    = 300;
  localparam int PAUSE  = 60;
  localparam int POINTS = 10;
  localparam int CYCLES = 45000;

  localparam int P_IDLE = 0, P_SPAWN = 1, P_FLY = 2, P_FALL = 3;
  localparam int P_ESC = 4, P_NEXT = 5, P_REND = 6, P_OVER = 7;

  logic        clk = 1'b0;
  logic        rst, new_frame, trigger, on_target, duck_escaped;
  logic        duck_spawn, duck_kill, fly_away, game_over;
  logic [1:0]  shots_left;
  logic [3:0]  ducks_done, hits, round;
  logic [15:0] score;
  logic [2:0]  state;

  game_ctl dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .trigger(trigger),
    .on_target(on_target), .duck_escaped(duck_escaped),
    .duck_spawn(duck_spawn), .duck_kill(duck_kill), .fly_away(fly_away),
    .shots_left(shots_left), .ducks_done(ducks_done), .hits(hits),
    .round(round), .score(score), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Expected output bundle for one cycle.
  typedef struct packed {
    logic        spawn;
    logic        kill;
    logic        fly;
    logic [1:0]  shots;
    logic [3:0]  ducks;
    logic [3:0]  hits;
    logic [3:0]  round;
    logic [15:0] score;
    logic [2:0]  phase;
    logic        over;
  } outs_t;

  outs_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Game model state.
  int m_phase, m_cnt, m_shots, m_ducks, m_hits, m_round, m_score;
  bit m_spawn, m_kill, m_fly, m_over;

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_shots = 0; m_ducks = 0; m_hits = 0;
    m_round = 1; m_score = 0; m_spawn = 0; m_kill = 0; m_fly = 0; m_over = 0;
  endtask

  // Advances the game by one clock with the given inputs.
  task automatic model_step(input bit r, input bit nf, input bit tr,
                            input bit ot, input bit esc);
    int  old_cnt;
    bit  decided;
    m_spawn = 0;
    m_kill  = 0;
    if (r) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE: if (tr) begin
        m_round = 1; m_score = 0; m_hits = 0; m_ducks = 0; m_phase = P_SPAWN;
      end
      P_SPAWN: begin
        m_spawn = 1; m_shots = SHOTS; m_cnt = 0; m_phase = P_FLY;
      end
      P_FLY: begin
        old_cnt = m_cnt;
        decided = 0;
        if (nf) m_cnt++;
        if (tr && m_shots > 0) begin
          m_shots--;
          if (ot) begin
            m_kill = 1;
            m_hits++;
            m_score = m_score + POINTS * m_round;
            if (m_score > 65535) m_score = 65535;
            m_cnt = 0; m_phase = P_FALL; decided = 1;
          end else if (m_shots == 0) begin
            m_fly = 1; m_cnt = 0; m_phase = P_ESC; decided = 1;
          end
        end
        if (!decided) begin
          if (esc) begin
            m_cnt = 0; m_phase = P_ESC;
          end else if (nf && old_cnt == TMO - 1) begin
            m_fly = 1; m_cnt = 0; m_phase = P_ESC;
          end
        end
      end
      P_FALL, P_ESC: if (nf) begin
        if (m_cnt == PAUSE - 1) begin
          m_cnt = 0; m_fly = 0; m_phase = P_NEXT;
        end else m_cnt++;
      end
      P_NEXT: begin
        m_ducks++;
        m_cnt = 0;
        m_phase = (m_ducks == DUCKS) ? P_REND : P_SPAWN;
      end
      P_REND: if (nf) begin
        if (m_cnt == PAUSE - 1) begin
          m_cnt = 0;
          if (m_hits >= PASS) begin
            m_round = (m_round < 15) ? m_round + 1 : 15;
            m_hits = 0; m_ducks = 0; m_phase = P_SPAWN;
          end else begin
            m_over = 1; m_phase = P_OVER;
          end
        end else m_cnt++;
      end
      default: if (tr) begin
        m_over = 0; m_phase = P_IDLE;
      end
    endcase
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.spawn = m_spawn;      o.kill  = m_kill;        o.fly   = m_fly;
    o.shots = 2'(m_shots);  o.ducks = 4'(m_ducks);   o.hits  = 4'(m_hits);
    o.round = 4'(m_round);  o.score = 16'(m_score);  o.phase = 3'(m_phase);
    o.over  = m_over;
    return o;
  endfunction

  function automatic void print_summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endfunction

  // Driver: random stimulus in phases with different click and hit rates.
  initial begin
    int trig_div, hit_pct;
    bit r, nf, tr, ot, esc;
    rst = 1'b1; new_frame = 1'b0; trigger = 1'b0; on_target = 1'b0;
    duck_escaped = 1'b0;
    model_reset();
    trig_div = 30; hit_pct = 60;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc % 1500 == 0) begin
        case ($urandom_range(0, 3))
          0: trig_div = 0;
          1: trig_div = 8;
          2: trig_div = 30;
          default: trig_div = 80;
        endcase
        case ($urandom_range(0, 2))
          0: hit_pct = 25;
          1: hit_pct = 70;
          default: hit_pct = 97;
        endcase
      end
      r   = (cyc < 3) || ($urandom_range(0, 2999) == 0);
      nf  = ($urandom_range(0, 1) == 0);
      tr  = (trig_div != 0) && ($urandom_range(0, trig_div - 1) == 0);
      ot  = ($urandom_range(0, 99) < hit_pct);
      esc = ($urandom_range(0, 699) == 0);
      rst = r; new_frame = nf; trigger = tr; on_target = ot; duck_escaped = esc;
      model_step(r, nf, tr, ot, esc);
      exp_q.push_back(model_outs());
    end
    @(negedge clk);
    rst = 1'b0; new_frame = 1'b0; trigger = 1'b0; duck_escaped = 1'b0;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0",
               exp_q.size());
    end
    print_summary();
    $finish;
  end

  // Monitor: after each clock edge, compare the DUT outputs with the model.
  initial begin
    outs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {duck_spawn, duck_kill, fly_away, shots_left, ducks_done, hits,
             round, score, state, game_over};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got state=%0d spawn=%0b kill=%0b fly=%0b shots=%0d ducks=%0d hits=%0d round=%0d score=%0d over=%0b required state=%0d spawn=%0b kill=%0b fly=%0b shots=%0d ducks=%0d hits=%0d round=%0d score=%0d over=%0b",
                   $time, g.phase, g.spawn, g.kill, g.fly, g.shots, g.ducks,
                   g.hits, g.round, g.score, g.over, e.phase, e.spawn, e.kill,
                   e.fly, e.shots, e.ducks, e.hits, e.round, e.score, e.over);
          if (miscompares >= 20) begin
            print_summary();
            $finish;
          end
        end else if (e.spawn) begin
          $display("t=%0t spawn  round=%0d ducks=%0d hits=%0d score=%0d",
                   $time, e.round, e.ducks, e.hits, e.score);
        end else if (e.kill) begin
          $display("t=%0t kill   round=%0d hits=%0d shots=%0d score=%0d",
                   $time, e.round, e.hits, e.shots, e.score);
        end
      end
    end
  end

endmodule

// File: doc/game_ctl.md
Name: game_ctl

Overview:
- Round/shot sequencer for the Duck Hunt game. Sits in the ctrl section beside ctl_duck.
- Decides when a duck is spawned, killed or sent away, based on trigger clicks, cursor-on-duck information and frame ticks.
- Maintains the shots, hits, ducks-per-round, round and score counters that the HUD drawing stages display.

Parameters:
- SHOTS_PER_DUCK, 3, shots granted per duck (1..3).
- DUCKS_PER_ROUND, 10, ducks per round (1..15).
- PASS_HITS, 6, minimum hits in a round to advance (<= DUCKS_PER_ROUND).
- FLY_TIMEOUT, 300, new_frame ticks before an unshot duck flies away.
- PAUSE_FRAMES, 60, new_frame ticks for the fall, escape and round-end pauses.
- HIT_POINTS, 10, base points per hit, multiplied by round.

Ports:
- clk  in  1  main 65 MHz clock
- rst  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle pulse per frame from vga_timing
- trigger  in  1  one-cycle pulse per mouse click, already synchronised to clk
- on_target  in  1  cursor inside duck bounding box, sampled with trigger
- duck_escaped  in  1  one-cycle pulse when the duck leaves the screen
- duck_spawn  out  1  one-cycle pulse: ctl_duck loads a new start position
- duck_kill  out  1  one-cycle pulse: ctl_duck starts the fall animation
- fly_away  out  1  level: duck exits upward
- shots_left  out  2  remaining shots for the current duck
- ducks_done  out  4  ducks finished in the current round
- hits  out  4  hits in the current round
- round  out  4  current round, 1..15
- score  out  16  accumulated score
- state  out  3  FSM state code, for HUD and debug
- game_over  out  1  level, high in GAME_OVER

Behaviour:
- Reset values: state=IDLE(0); all pulses, fly_away and game_over 0; shots_left=0, ducks_done=0, hits=0, round=1, score=0. frame_cnt=0.
- All outputs are registered. Pulses are exactly one clk wide.
- States and codes: IDLE=0, SPAWN=1, FLY=2, FALL=3, ESCAPE=4, NEXT=5, ROUND_END=6, OVER=7.
- IDLE
  - trigger -> SPAWN.
  - On that transition: round=1, score=0, hits=0, ducks_done=0.
- SPAWN (1 cycle)
  - duck_spawn=1, shots_left=SHOTS_PER_DUCK, frame_cnt=0 -> FLY.
- FLY
  - new_frame increments frame_cnt.
  - Event priority, highest first: trigger, then duck_escaped, then timeout.
  - Trigger with shots_left>0: shots_left-1.
    - If on_target: duck_kill=1, hits+1, score+=HIT_POINTS*round (saturate at 65535), frame_cnt=0 -> FALL.
    - Else, if this was the last shot: fly_away=1, frame_cnt=0 -> ESCAPE.
  - Trigger with shots_left=0: ignored.
  - duck_escaped: frame_cnt=0 -> ESCAPE.
  - Timeout, i.e. frame_cnt==FLY_TIMEOUT-1 on a new_frame: fly_away=1, frame_cnt=0 -> ESCAPE.
- FALL and ESCAPE
  - Count new_frame ticks; after PAUSE_FRAMES ticks -> NEXT.
  - Clear fly_away on exit.
  - Triggers are ignored.
- NEXT (1 cycle)
  - ducks_done+1.
  - If the new value == DUCKS_PER_ROUND -> ROUND_END, else -> SPAWN.
- ROUND_END
  - After PAUSE_FRAMES ticks:
    - If hits>=PASS_HITS: round+1 (saturate at 15), hits=0, ducks_done=0 -> SPAWN.
    - Else -> OVER.
- OVER
  - game_over=1.
  - trigger -> IDLE, clearing game_over.
- Width rules: score product is computed in 16 bits; HIT_POINTS*15 must fit.
- Reset mid-operation: immediate return to reset values on the next clk edge. No pulse is emitted on the reset cycle.
- new_frame and trigger in the same cycle: both are processed. frame_cnt increments, then the trigger decision applies; the trigger result wins the state transition.
- duck_escaped outside FLY: ignored.

Test Plan:
- Reset, then trigger in IDLE -> duck_spawn pulse 1 cycle after SPAWN entry; state 0->1->2; shots_left=3, round=1, score=0.
- FLY, trigger with on_target=1 -> duck_kill pulse, hits=1, score=10, shots_left=2. After 60 new_frames -> ducks_done=1 and duck_spawn again.
- FLY, three triggers with on_target=0 -> shots_left 2,1,0. fly_away=1 after the third. A fourth trigger changes nothing. Fly_away clears after 60 frames.
- FLY, no trigger for 300 new_frames -> fly_away=1 exactly on the 300th tick. Trigger and timeout in the same cycle with on_target=1 -> hit wins.
- Full round, 6 hits out of 10 -> round=2, hits=0, ducks_done=0; the next round's hits score 20 each. Full round with 5 hits -> state=7, game_over=1; trigger -> IDLE, game_over=0.
- Assert rst during FALL -> next cycle state=0, all counters at reset values, no duck_kill or duck_spawn pulse.
